// File: rtl/rs232_frame_link_if.sv
// -----------------------------------------------------------------------------
// rs232_frame_link_if
//   Bundles the byte-stream, reply and frame-report signals of the RS232 frame
//   link. The link block itself uses the slave view; whatever feeds it bytes,
//   acknowledges transmissions and consumes frame reports uses the master view.
//
//   RX_DATA     8            byte from UART receiver
//   RX_VALID    1            one-cycle strobe, RX_DATA valid
//   TX_DATA     8            reply byte (ACK/NAK) to UART transmitter
//   TX_TRG      1            one-cycle write trigger to UART transmitter
//   TX_DONE     1            one-cycle strobe, UART finished sending
//   FRAME_ADDR  8*ADDR_BYTES address of the last good frame
//   FRAME_DATA  8*DATA_BYTES data of the last good frame
//   FRAME_VALID 1            one-cycle pulse, good frame delivered
//   FRAME_ERR   1            one-cycle pulse, frame rejected
//   ERR_CODE    2            01 checksum, 10 timeout; held until next rejection
//   DROP_CNT    8            saturating count of bytes dropped while busy
//
//   ADDR_BYTES / DATA_BYTES must match the parameters of the link instance.
// -----------------------------------------------------------------------------
interface rs232_frame_link_if #(
   parameter int ADDR_BYTES = 1,
   parameter int DATA_BYTES = 1
);
   logic [7:0]              RX_DATA;
   logic                    RX_VALID;
   logic [7:0]              TX_DATA;
   logic                    TX_TRG;
   logic                    TX_DONE;
   logic [8*ADDR_BYTES-1:0] FRAME_ADDR;
   logic [8*DATA_BYTES-1:0] FRAME_DATA;
   logic                    FRAME_VALID;
   logic                    FRAME_ERR;
   logic [1:0]              ERR_CODE;
   logic [7:0]              DROP_CNT;

   // Host / UART side
   modport master (
      output RX_DATA, RX_VALID, TX_DONE,
      input  TX_DATA, TX_TRG, FRAME_ADDR, FRAME_DATA, FRAME_VALID, FRAME_ERR,
             ERR_CODE, DROP_CNT
   );

   // Frame link side
   modport slave (
      input  RX_DATA, RX_VALID, TX_DONE,
      output TX_DATA, TX_TRG, FRAME_ADDR, FRAME_DATA, FRAME_VALID, FRAME_ERR,
             ERR_CODE, DROP_CNT
   );
endinterface

// File: rtl/rs232_frame_link.sv
// -----------------------------------------------------------------------------
// rs232_frame_link
//   Parses the UART receive byte stream into frames of
//   [ADDR_BYTES address][DATA_BYTES data][optional XOR checksum], reports each
//   completed frame (good or rejected), then answers the host with an ACK or
//   NAK byte through the UART transmitter. An inter-byte timeout aborts stalled
//   frames; bytes arriving while a reply is in progress are dropped and counted.
//
//   CLK_50MHZ  in   main clock
//   RST        in   asynchronous reset, active-high
//   bus        rs232_frame_link_if.slave
//                   RX_DATA/RX_VALID in, TX_DATA/TX_TRG out, TX_DONE in,
//                   FRAME_ADDR/FRAME_DATA/FRAME_VALID/FRAME_ERR/ERR_CODE/DROP_CNT out
// -----------------------------------------------------------------------------
module rs232_frame_link #(
   parameter int         ADDR_BYTES   = 1,
   parameter int         DATA_BYTES   = 1,
   parameter bit         USE_CHECKSUM = 1'b1,
   parameter int         TIMEOUT_CYC  = 50000,
   parameter logic [7:0] ACK_BYTE     = 8'h06,
   parameter logic [7:0] NAK_BYTE     = 8'h15
) (
   input  logic              CLK_50MHZ,
   input  logic              RST,
   rs232_frame_link_if.slave bus
);

   localparam int AW        = 8 * ADDR_BYTES;
   localparam int DW        = 8 * DATA_BYTES;
   localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
   localparam int IDX_W     = $clog2(MAX_BYTES + 1);
   localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);

   localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BYTES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      GET_CSUM,
      REPORT,
      SEND,
      WAIT_TX
   } state_t;

   state_t           state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [TMO_W-1:0] tmo_reg;
   logic [7:0]       csum_reg;
   logic [AW-1:0]    addr_sh_reg;
   logic [DW-1:0]    data_sh_reg;
   logic             nak_reg;

   logic [AW-1:0]    frame_addr_reg;
   logic [DW-1:0]    frame_data_reg;
   logic             frame_valid_reg;
   logic             frame_err_reg;
   logic [1:0]       err_code_reg;
   logic [7:0]       tx_data_reg;
   logic             tx_trg_reg;
   logic [7:0]       drop_cnt_reg;

   logic [AW-1:0]    addr_shift_next;
   logic [DW-1:0]    data_shift_next;
   logic [7:0]       csum_next;
   logic             rx_drop;

   // Shadow registers shift left one byte per accepted byte; the newest byte
   // lands in the least significant lane so the first byte ends up as MSB.
   genvar gi;
   for (gi = 0; gi < ADDR_BYTES; gi++) begin : g_addr_lane
      if (gi == 0) begin : g_lsb
         assign addr_shift_next[7:0] = bus.RX_DATA;
      end else begin : g_upper
         assign addr_shift_next[8*gi +: 8] = addr_sh_reg[8*(gi-1) +: 8];
      end
   end

   for (gi = 0; gi < DATA_BYTES; gi++) begin : g_data_lane
      if (gi == 0) begin : g_lsb
         assign data_shift_next[7:0] = bus.RX_DATA;
      end else begin : g_upper
         assign data_shift_next[8*gi +: 8] = data_sh_reg[8*(gi-1) +: 8];
      end
   end

   assign csum_next = csum_reg ^ bus.RX_DATA;
   assign rx_drop   = bus.RX_VALID &&
                      (state_reg == REPORT || state_reg == SEND || state_reg == WAIT_TX);

   always_ff @(posedge CLK_50MHZ or posedge RST) begin
      if (RST) begin
         state_reg       <= IDLE;
         idx_reg         <= '0;
         tmo_reg         <= '0;
         csum_reg        <= '0;
         addr_sh_reg     <= '0;
         data_sh_reg     <= '0;
         nak_reg         <= 1'b0;
         frame_addr_reg  <= '0;
         frame_data_reg  <= '0;
         frame_valid_reg <= 1'b0;
         frame_err_reg   <= 1'b0;
         err_code_reg    <= 2'b00;
         tx_data_reg     <= 8'h00;
         tx_trg_reg      <= 1'b0;
      end else begin
         // Report and trigger outputs are single-cycle pulses.
         frame_valid_reg <= 1'b0;
         frame_err_reg   <= 1'b0;
         tx_trg_reg      <= 1'b0;

         case (state_reg)
            IDLE: begin
               idx_reg  <= '0;
               tmo_reg  <= '0;
               csum_reg <= '0;
               if (bus.RX_VALID) begin
                  addr_sh_reg <= addr_shift_next;
                  csum_reg    <= bus.RX_DATA;
                  if (ADDR_BYTES == 1) begin
                     state_reg <= GET_DATA;
                     idx_reg   <= '0;
                  end else begin
                     state_reg <= GET_ADDR;
                     idx_reg   <= IDX_W'(1);
                  end
               end
            end

            GET_ADDR, GET_DATA, GET_CSUM: begin
               if (bus.RX_VALID) begin
                  // A byte on the last timeout cycle still wins.
                  tmo_reg  <= '0;
                  csum_reg <= csum_next;
                  if (state_reg == GET_ADDR) begin
                     addr_sh_reg <= addr_shift_next;
                     if (idx_reg == ADDR_LAST) begin
                        state_reg <= GET_DATA;
                        idx_reg   <= '0;
                     end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                     end
                  end else if (state_reg == GET_DATA) begin
                     data_sh_reg <= data_shift_next;
                     if (idx_reg == DATA_LAST) begin
                        idx_reg <= '0;
                        if (USE_CHECKSUM) begin
                           state_reg <= GET_CSUM;
                        end else begin
                           state_reg       <= REPORT;
                           frame_valid_reg <= 1'b1;
                           frame_addr_reg  <= addr_sh_reg;
                           frame_data_reg  <= data_shift_next;
                           nak_reg         <= 1'b0;
                        end
                     end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                     end
                  end else begin
                     // Checksum byte: compared against XOR of address and data only.
                     state_reg <= REPORT;
                     if (bus.RX_DATA == csum_reg) begin
                        frame_valid_reg <= 1'b1;
                        frame_addr_reg  <= addr_sh_reg;
                        frame_data_reg  <= data_sh_reg;
                        nak_reg         <= 1'b0;
                     end else begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= 2'b01;
                        nak_reg       <= 1'b1;
                     end
                  end
               end else if (tmo_reg == TMO_LAST) begin
                  state_reg     <= REPORT;
                  frame_err_reg <= 1'b1;
                  err_code_reg  <= 2'b10;
                  nak_reg       <= 1'b1;
                  tmo_reg       <= '0;
               end else begin
                  tmo_reg <= tmo_reg + TMO_W'(1);
               end
            end

            REPORT: begin
               state_reg   <= SEND;
               tx_trg_reg  <= 1'b1;
               tx_data_reg <= nak_reg ? NAK_BYTE : ACK_BYTE;
            end

            SEND: begin
               state_reg <= WAIT_TX;
            end

            WAIT_TX: begin
               if (bus.TX_DONE) begin
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Dropped-byte accounting survives frames; only reset clears it.
   always_ff @(posedge CLK_50MHZ or posedge RST) begin
      if (RST) begin
         drop_cnt_reg <= 8'h00;
      end else if (rx_drop && (drop_cnt_reg != 8'hFF)) begin
         drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
   end

   assign bus.TX_DATA     = tx_data_reg;
   assign bus.TX_TRG      = tx_trg_reg;
   assign bus.FRAME_ADDR  = frame_addr_reg;
   assign bus.FRAME_DATA  = frame_data_reg;
   assign bus.FRAME_VALID = frame_valid_reg;
   assign bus.FRAME_ERR   = frame_err_reg;
   assign bus.ERR_CODE    = err_code_reg;
   assign bus.DROP_CNT    = drop_cnt_reg;

endmodule

// File: tb/tb_rs232_frame_link.sv
// -----------------------------------------------------------------------------
// tb_rs232_frame_link
//   Drives frames of [1 addr][2 data][XOR checksum] with TIMEOUT_CYC=100.
//   The stimulus process predicts each frame outcome (good, checksum error,
//   timeout) and its cycle, pushing them into queues; a monitor pops and
//   compares on every FRAME_VALID/FRAME_ERR/TX_TRG. A UART model answers each
//   TX_TRG with a TX_DONE strobe after a programmable delay.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rs232_frame_link;

   localparam int         ADDR_BYTES = 1;
   localparam int         DATA_BYTES = 2;
   localparam int         TIMEOUT    = 100;
   localparam logic [7:0] ACK        = 8'h06;
   localparam logic [7:0] NAK        = 8'h15;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   rs232_frame_link_if #(.ADDR_BYTES(ADDR_BYTES), .DATA_BYTES(DATA_BYTES)) bus_if ();

   rs232_frame_link #(
      .ADDR_BYTES   (ADDR_BYTES),
      .DATA_BYTES   (DATA_BYTES),
      .USE_CHECKSUM (1'b1),
      .TIMEOUT_CYC  (TIMEOUT),
      .ACK_BYTE     (ACK),
      .NAK_BYTE     (NAK)
   ) u_dut (
      .CLK_50MHZ (clk),
      .RST       (rst),
      .bus       (bus_if)
   );

   typedef struct {
      bit          is_err;
      logic [1:0]  code;
      logic [7:0]  addr;
      logic [15:0] data;
      int          cyc;
   } frame_exp_t;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } tx_exp_t;

   frame_exp_t frame_q[$];
   tx_exp_t    tx_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference state: last good frame, held error code, dropped bytes.
   logic [7:0]  m_addr;
   logic [15:0] m_data;
   logic [1:0]  m_code;
   int          m_drops;

   int done_delay = 2;
   int done_cnt   = 0;
   int frames_run = 0;
   int tx_seen    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_frame_addr"},  32'(bus_if.FRAME_ADDR),  0);
      chk({tag, "_frame_data"},  32'(bus_if.FRAME_DATA),  0);
      chk({tag, "_frame_flags"}, {30'd0, bus_if.FRAME_VALID, bus_if.FRAME_ERR}, 0);
      chk({tag, "_err_code"},    32'(bus_if.ERR_CODE),    0);
      chk({tag, "_tx"},          {23'd0, bus_if.TX_TRG, bus_if.TX_DATA}, 0);
      chk({tag, "_drop_cnt"},    32'(bus_if.DROP_CNT),    0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      frame_exp_t fe;
      tx_exp_t    te;
      if (!rst) begin
         if (bus_if.FRAME_VALID || bus_if.FRAME_ERR) begin
            $display("report cyc=%0d valid=%0b err=%0b addr=%02h data=%04h code=%02b",
                     cyc, bus_if.FRAME_VALID, bus_if.FRAME_ERR, bus_if.FRAME_ADDR,
                     bus_if.FRAME_DATA, bus_if.ERR_CODE);
            if (frame_q.size() == 0) begin
               chk("unexpected_report", {30'd0, bus_if.FRAME_VALID, bus_if.FRAME_ERR}, 0);
            end else begin
               fe = frame_q.pop_front();
               chk("report_kind",  {30'd0, bus_if.FRAME_VALID, bus_if.FRAME_ERR},
                   fe.is_err ? 32'd1 : 32'd2);
               chk("report_cycle", cyc, fe.cyc);
               chk("frame_addr",   32'(bus_if.FRAME_ADDR), 32'(fe.addr));
               chk("frame_data",   32'(bus_if.FRAME_DATA), 32'(fe.data));
               chk("err_code",     32'(bus_if.ERR_CODE),   32'(fe.code));
            end
         end
         if (bus_if.TX_TRG) begin
            tx_seen++;
            $display("tx cyc=%0d byte=%02h", cyc, bus_if.TX_DATA);
            if (tx_q.size() == 0) begin
               chk("unexpected_tx_trg", 32'(bus_if.TX_TRG), 0);
            end else begin
               te = tx_q.pop_front();
               chk("tx_data",  32'(bus_if.TX_DATA), 32'(te.data));
               chk("tx_cycle", cyc, te.cyc);
            end
         end
      end
   end

   // ---------------- UART transmitter model ----------------
   initial begin
      int d;
      bus_if.TX_DONE = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.TX_TRG && !rst) begin
            d = done_delay;
            repeat (d) @(posedge clk);
            #1 bus_if.TX_DONE = 1'b1;
            @(posedge clk);
            #1 bus_if.TX_DONE = 1'b0;
            done_cnt++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called #1 after a clock edge; returns #1 after the edge that sampled the byte.
   task automatic send_byte(input logic [7:0] b, input int idle, output int edge_cyc);
      repeat (idle) begin
         @(posedge clk);
         #1;
      end
      bus_if.RX_DATA  = b;
      bus_if.RX_VALID = 1'b1;
      @(posedge clk);
      #1;
      bus_if.RX_VALID = 1'b0;
      edge_cyc = cyc;
   endtask

   task automatic wait_done();
      int w;
      w = 0;
      while (done_cnt != frames_run && w < 2000) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("tx_done_handshake", done_cnt, frames_run);
   endtask

   // bytes = {addr, data_hi, data_lo, csum}; gN = idle cycles before byte N.
   // A gap of TIMEOUT or more ends the frame with a timeout before that byte.
   task automatic run_frame(input logic [31:0] bytes, input int g0, input int g1,
                            input int g2, input int g3, input int n_drops, input int dly);
      logic [7:0] fb [4];
      int         gp [4];
      int         e;
      int         i;
      int         dummy;
      bit         timed_out;
      frame_exp_t fe;
      tx_exp_t    te;
      fb[0] = bytes[31:24]; fb[1] = bytes[23:16]; fb[2] = bytes[15:8]; fb[3] = bytes[7:0];
      gp[0] = g0; gp[1] = g1; gp[2] = g2; gp[3] = g3;
      done_delay = dly;
      timed_out  = 1'b0;
      e = 0;
      i = 0;
      while (i < 4 && !timed_out) begin
         if (i > 0 && gp[i] >= TIMEOUT) timed_out = 1'b1;
         else begin
            send_byte(fb[i], gp[i], e);
            i++;
         end
      end
      if (timed_out) begin
         m_code    = 2'b10;
         fe.is_err = 1'b1;
         fe.cyc    = e + TIMEOUT;
         te.data   = NAK;
      end else if (fb[3] == (fb[0] ^ fb[1] ^ fb[2])) begin
         m_addr    = fb[0];
         m_data    = {fb[1], fb[2]};
         fe.is_err = 1'b0;
         fe.cyc    = e;
         te.data   = ACK;
      end else begin
         m_code    = 2'b01;
         fe.is_err = 1'b1;
         fe.cyc    = e;
         te.data   = NAK;
      end
      fe.code = m_code;
      fe.addr = m_addr;
      fe.data = m_data;
      te.cyc  = fe.cyc + 1;
      frame_q.push_back(fe);
      tx_q.push_back(te);
      if (timed_out) begin
         repeat (TIMEOUT) begin
            @(posedge clk);
            #1;
         end
      end
      // Extra strobes from the report cycle onwards must all be dropped.
      for (int j = 0; j < n_drops; j++) send_byte(8'($urandom), 0, dummy);
      m_drops = (m_drops + n_drops > 255) ? 255 : m_drops + n_drops;
      frames_run++;
      wait_done();
      chk("drop_cnt",         32'(bus_if.DROP_CNT),   m_drops);
      chk("frame_addr_hold",  32'(bus_if.FRAME_ADDR), 32'(m_addr));
      chk("frame_data_hold",  32'(bus_if.FRAME_DATA), 32'(m_data));
      chk("err_code_hold",    32'(bus_if.ERR_CODE),   32'(m_code));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #(20 * 80000);
      $display("FAIL watchdog: simulation exceeded cycle budget (cycle %0d)", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int         e;
      int         tx_before;
      int         g [4];
      int         r;
      logic [7:0] a, d0, d1, cs;

      rst             = 1'b1;
      bus_if.RX_DATA  = 8'h00;
      bus_if.RX_VALID = 1'b0;
      m_addr = 8'h00; m_data = 16'h0000; m_code = 2'b00; m_drops = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Good frame, then checksum error keeping the previous frame outputs.
      run_frame(32'h0E12_3428, 0, 0, 0, 0, 0, 2);
      run_frame(32'h0E12_3429, 0, 0, 0, 0, 0, 2);

      // Stall after two bytes -> timeout; byte on the last allowed cycle wins.
      run_frame(32'h0E12_0000, 0, 0, TIMEOUT + 5, 0, 0, 3);
      run_frame(32'h0E12_3428, 0, 0, TIMEOUT - 1, TIMEOUT - 1, 0, 2);
      run_frame(32'h5A00_0000, 1, TIMEOUT, 0, 0, 0, 2);

      // Drops while replying, then saturation.
      run_frame(32'h2233_4455, 0, 1, 1, 1, 3, 10);
      run_frame(32'h7788_99EE, 0, 0, 0, 0, 300, 310);
      chk("drop_saturated", 32'(bus_if.DROP_CNT), 255);

      // Reset mid-frame: partial frame discarded, no reply.
      send_byte(8'h0E, 0, e);
      send_byte(8'h12, 0, e);
      rst = 1'b1;
      #1;
      chk_outputs_zero("midframe_reset");
      m_addr = 8'h00; m_data = 16'h0000; m_code = 2'b00; m_drops = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tx_before = tx_seen;
      repeat (TIMEOUT + 20) @(posedge clk);
      #1;
      chk("no_tx_after_reset", tx_seen, tx_before);
      run_frame(32'h0100_0504, 0, 0, 0, 0, 0, 2);

      // Back-to-back frames, TX_DONE two cycles after TX_TRG.
      run_frame(32'hA1B2_C3D0, 0, 0, 0, 0, 0, 2);
      run_frame(32'h1020_3000, 0, 0, 0, 0, 0, 2);

      // Randomised frames.
      for (int f = 0; f < 40; f++) begin
         a  = 8'($urandom);
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         cs = a ^ d0 ^ d1;
         if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
         g[0] = $urandom_range(0, 3);
         for (int k = 1; k < 4; k++) begin
            r = $urandom_range(0, 11);
            if (r == 0)      g[k] = TIMEOUT - 1;
            else if (r == 1) g[k] = TIMEOUT + $urandom_range(0, 5);
            else             g[k] = $urandom_range(0, 4);
         end
         run_frame({a, d0, d1, cs}, g[0], g[1], g[2], g[3],
                   $urandom_range(0, 2), $urandom_range(4, 8));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("pending_reports", frame_q.size(), 0);
      chk("pending_tx",      tx_q.size(),    0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
